// File: rtl/apb_spi_fifo_regs.sv
// apb_spi_fifo_regs: APB register front-end for the SPI master core.
// Provides CR1/CR2/BR control registers, a status register, a FIFO level
// register, a TX and an RX FIFO behind the DR address, sticky modf/ovr flags
// with write-1-to-clear, PSLVERR decoding and the RUN/WAIT/STOP mode FSM.
// Ports:
//   Pclk, Presetn            clock, asynchronous active-low reset
//   PADDR..PSLVERR           APB slave (zero wait states)
//   ss, tip                  slave-select pin, transfer in progress
//   rx_data/rx_valid         received word push strobe from the core
//   tx_data/tx_valid/tx_ready TX FIFO head handshake to the core
//   mstr..spr                control/baud fields to core and baud generator
//   spi_mode                 low-power FSM state (RUN=00, WAIT=01, STOP=10)
//   spi_interrupt_request    interrupt line
module apb_spi_fifo_regs #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int APB_DW     = 16
) (
  input  logic              Pclk,
  input  logic              Presetn,
  input  logic [2:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              ss,
  input  logic              tip,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic              spi_interrupt_request
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN = 2'b00, WAIT = 2'b01, STOP = 2'b10} mode_e;

  mode_e mode_q, mode_d;
  logic [7:0] cr1_q, cr2_q, br_q;
  logic modf_q, ovr_q;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;

  logic access, wr_ok, rd_ok, err;
  logic tx_full, rx_full, rx_empty, tx_empty;
  logic tx_push, tx_pop, rx_en, rx_push, rx_pop, icr_wr;
  logic modf_set, ovr_set, spif, sptef;
  logic [7:0] sr;
  logic unused_pwdata;

  assign unused_pwdata = ^PWDATA;

  assign access   = PSEL & PENABLE;
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_empty = (rx_cnt_q == '0);
  assign spif     = ~rx_empty;
  assign sptef    = ~tx_full;
  assign sr       = {spif, 1'b0, sptef, modf_q, ovr_q, tx_full, rx_full, tip};

  // Error decode; judged on pre-edge state so an errored access changes nothing.
  always_comb begin
    err = 1'b0;
    case (PADDR)
      3'd0, 3'd1, 3'd2: err = PWRITE & tip;
      3'd3, 3'd4:       err = PWRITE;
      3'd5:             err = PWRITE ? tx_full : rx_empty;
      3'd6:             err = 1'b0;
      default:          err = 1'b1;
    endcase
  end

  assign PREADY  = access;
  assign PSLVERR = access & err;
  assign wr_ok   = access & PWRITE & ~err;
  assign rd_ok   = access & ~PWRITE & ~err;

  // Read mux, driven only during the access phase.
  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      case (PADDR)
        3'd0:    PRDATA = APB_DW'(cr1_q);
        3'd1:    PRDATA = APB_DW'(cr2_q);
        3'd2:    PRDATA = APB_DW'(br_q);
        3'd3:    PRDATA = APB_DW'(sr);
        3'd4:    PRDATA = APB_DW'({8'(rx_cnt_q), 8'(tx_cnt_q)});
        3'd5:    PRDATA = rx_empty ? '0 : APB_DW'(rx_mem[rx_rp_q]);
        default: PRDATA = '0;
      endcase
    end else begin
      PRDATA = '0;
    end
  end

  assign tx_data  = tx_mem[tx_rp_q];
  assign tx_valid = ~tx_empty & (mode_q != STOP);
  assign tx_push  = wr_ok & (PADDR == 3'd5);
  assign tx_pop   = tx_valid & tx_ready;

  // A full RX FIFO still accepts a push when a DR read frees a slot this cycle.
  assign rx_en    = rx_valid & (mode_q != STOP);
  assign rx_pop   = rd_ok & (PADDR == 3'd5);
  assign rx_push  = rx_en & (~rx_full | rx_pop);
  assign ovr_set  = rx_en & rx_full & ~rx_pop;
  assign icr_wr   = wr_ok & (PADDR == 3'd6);
  assign modf_set = cr2_q[4] & cr1_q[4] & ~ss & ~cr1_q[1];

  // Control registers and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      cr1_q  <= 8'h04;
      cr2_q  <= 8'h00;
      br_q   <= 8'h00;
      modf_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_ok && PADDR == 3'd0) cr1_q <= PWDATA[7:0];
      if (wr_ok && PADDR == 3'd1) cr2_q <= PWDATA[7:0] & 8'h1B;
      if (wr_ok && PADDR == 3'd2) br_q  <= PWDATA[7:0] & 8'h77;
      if (modf_set)                    modf_q <= 1'b1;
      else if (icr_wr && PWDATA[4])    modf_q <= 1'b0;
      if (ovr_set)                     ovr_q  <= 1'b1;
      else if (icr_wr && PWDATA[3])    ovr_q  <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since counts gate visibility.
  always_ff @(posedge Pclk) begin
    if (tx_push) tx_mem[tx_wp_q] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

  // FIFO pointers and counts; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
    end
  end

  // Mode FSM state register.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) mode_q <= RUN;
    else          mode_q <= mode_d;
  end

  // Mode FSM next state: spe returns to RUN, spiswai selects STOP over WAIT.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      RUN:     mode_d = cr1_q[6] ? RUN : WAIT;
      WAIT:    mode_d = cr1_q[6] ? RUN : (cr2_q[1] ? STOP : WAIT);
      STOP:    mode_d = cr1_q[6] ? RUN : (cr2_q[1] ? STOP : WAIT);
      default: mode_d = RUN;
    endcase
  end

  assign spi_mode = mode_q;
  assign mstr     = cr1_q[4];
  assign cpol     = cr1_q[3];
  assign cpha     = cr1_q[2];
  assign lsbfe    = cr1_q[0];
  assign spiswai  = cr2_q[1];
  assign sppr     = br_q[6:4];
  assign spr      = br_q[2:0];
  assign spi_interrupt_request = (cr1_q[7] & (spif | modf_q | ovr_q)) | (cr1_q[5] & sptef);

endmodule

// File: tb/tb_apb_spi_fifo_regs.sv
// Directed testbench for apb_spi_fifo_regs with hand-computed expectations.
module tb_apb_spi_fifo_regs;

  logic        Pclk = 1'b0;
  logic        Presetn;
  logic [2:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        ss, tip, rx_valid, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0]  sppr, spr;
  logic [1:0]  spi_mode;
  logic        spi_interrupt_request;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] rd_v;
  logic        err_v;
  logic        rdy_v;

  always #5 Pclk = ~Pclk;

  apb_spi_fifo_regs #(.DATA_W(8), .FIFO_DEPTH(8), .APB_DW(16)) dut (
    .Pclk(Pclk), .Presetn(Presetn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ss(ss), .tip(tip), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .mstr(mstr), .cpol(cpol), .cpha(cpha),
    .lsbfe(lsbfe), .spiswai(spiswai), .sppr(sppr), .spr(spr), .spi_mode(spi_mode),
    .spi_interrupt_request(spi_interrupt_request)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [2:0] a, input logic [15:0] d, output logic e);
    @(negedge Pclk);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge Pclk);
    PENABLE = 1'b1;
    #1 e = PSLVERR; rdy_v = PREADY;
    @(negedge Pclk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [2:0] a, output logic [15:0] d, output logic e);
    @(negedge Pclk);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge Pclk);
    PENABLE = 1'b1;
    #1 d = PRDATA; e = PSLVERR; rdy_v = PREADY;
    @(negedge Pclk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    Presetn = 1'b0; PADDR = 3'd0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = 16'h0; ss = 1'b1; tip = 1'b0; rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge Pclk);
    chk("rst_prdata", PRDATA, 16'h0);
    chk("rst_pready", PREADY, 1'b0);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_txvalid", tx_valid, 1'b0);
    chk("rst_irq", spi_interrupt_request, 1'b0);
    Presetn = 1'b1;
    @(negedge Pclk);
    chk("mode_wait_after_rst", spi_mode, 2'b01);
    apb_rd(3'd0, rd_v, err_v); chk("cr1_reset", rd_v, 16'h0004);
    chk("pready_access", rdy_v, 1'b1);
    apb_rd(3'd3, rd_v, err_v); chk("sr_reset", rd_v, 16'h0020);
    apb_rd(3'd4, rd_v, err_v); chk("lvl_reset", rd_v, 16'h0000);

    // Error decode on unmapped / read-only / tip-locked writes
    apb_rd(3'd7, rd_v, err_v); chk("addr7_err", err_v, 1'b1);
    apb_wr(3'd3, 16'h00FF, err_v); chk("sr_wr_err", err_v, 1'b1);
    apb_wr(3'd2, 16'h00FF, err_v); chk("br_wr_err", err_v, 1'b0);
    apb_rd(3'd2, rd_v, err_v); chk("br_mask", rd_v, 16'h0077);
    chk("sppr", sppr, 3'd7);
    tip = 1'b1;
    apb_wr(3'd1, 16'h001B, err_v); chk("tip_wr_err", err_v, 1'b1);
    tip = 1'b0;
    apb_rd(3'd1, rd_v, err_v); chk("cr2_unchanged", rd_v, 16'h0000);

    // TX fill
    apb_wr(3'd0, 16'h0050, err_v); chk("cr1_wr", err_v, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apb_wr(3'd5, 16'h0011 + 16'(i), err_v); chk("tx_push_err", err_v, 1'b0);
    end
    apb_rd(3'd4, rd_v, err_v); chk("lvl_tx8", rd_v, 16'h0008);
    apb_rd(3'd3, rd_v, err_v); chk("sr_txfull", rd_v, 16'h0004);
    apb_wr(3'd5, 16'h0099, err_v); chk("tx_overflow_err", err_v, 1'b1);
    apb_rd(3'd4, rd_v, err_v); chk("lvl_unchanged", rd_v, 16'h0008);
    chk("mode_run", spi_mode, 2'b00);

    // TX drain
    @(negedge Pclk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tx_valid_drain", tx_valid, 1'b1);
      chk("tx_data_order", tx_data, 8'h11 + 8'(i));
      @(negedge Pclk);
    end
    tx_ready = 1'b0;
    chk("tx_valid_empty", tx_valid, 1'b0);
    apb_rd(3'd3, rd_v, err_v); chk("sr_sptef", rd_v, 16'h0020);

    // RX fill with overrun
    @(negedge Pclk);
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'hA0 + 8'(i); rx_valid = 1'b1;
      @(negedge Pclk);
    end
    rx_valid = 1'b0;
    apb_rd(3'd4, rd_v, err_v); chk("lvl_rx8", rd_v, 16'h0800);
    apb_rd(3'd3, rd_v, err_v); chk("sr_rx_ovr", rd_v, 16'h00AA);
    for (int i = 0; i < 8; i++) begin
      apb_rd(3'd5, rd_v, err_v);
      chk("rx_data_order", rd_v, 16'h00A0 + 16'(i));
      chk("rx_pop_err", err_v, 1'b0);
    end
    apb_rd(3'd5, rd_v, err_v); chk("rx_empty_err", err_v, 1'b1);
    chk("rx_empty_data", rd_v, 16'h0000);
    apb_rd(3'd6, rd_v, err_v); chk("icr_read_zero", rd_v, 16'h0000);
    apb_wr(3'd6, 16'h0008, err_v);
    apb_rd(3'd3, rd_v, err_v); chk("sr_ovr_clr", rd_v, 16'h0020);

    // Mode fault
    apb_wr(3'd1, 16'h0010, err_v);
    apb_wr(3'd0, 16'h00D0, err_v);
    chk("irq_idle", spi_interrupt_request, 1'b0);
    ss = 1'b0;
    @(negedge Pclk);
    chk("irq_modf", spi_interrupt_request, 1'b1);
    apb_rd(3'd3, rd_v, err_v); chk("sr_modf", rd_v, 16'h0030);
    apb_wr(3'd6, 16'h0010, err_v);
    apb_rd(3'd3, rd_v, err_v); chk("modf_set_wins", rd_v, 16'h0030);
    ss = 1'b1;
    apb_wr(3'd6, 16'h0010, err_v);
    apb_rd(3'd3, rd_v, err_v); chk("sr_modf_clr", rd_v, 16'h0020);
    chk("irq_clr", spi_interrupt_request, 1'b0);

    // STOP mode
    apb_wr(3'd1, 16'h0002, err_v);
    apb_wr(3'd0, 16'h0010, err_v);
    repeat (3) @(negedge Pclk);
    chk("mode_stop", spi_mode, 2'b10);
    chk("spiswai", spiswai, 1'b1);
    apb_wr(3'd5, 16'h0055, err_v);
    tx_ready = 1'b1;
    @(negedge Pclk);
    chk("tx_valid_stop", tx_valid, 1'b0);
    rx_data = 8'h77; rx_valid = 1'b1;
    repeat (2) @(negedge Pclk);
    rx_valid = 1'b0; tx_ready = 1'b0;
    apb_rd(3'd4, rd_v, err_v); chk("lvl_stop", rd_v, 16'h0001);
    apb_rd(3'd3, rd_v, err_v); chk("sr_stop_no_ovr", rd_v, 16'h0020);
    apb_wr(3'd0, 16'h0050, err_v);
    @(negedge Pclk);
    chk("mode_run_again", spi_mode, 2'b00);
    chk("tx_valid_resume", tx_valid, 1'b1);
    chk("tx_data_resume", tx_data, 8'h55);

    // Asynchronous reset empties FIFOs at once
    #2 Presetn = 1'b0;
    #1 chk("async_rst_txvalid", tx_valid, 1'b0);
    @(negedge Pclk);
    Presetn = 1'b1;
    apb_rd(3'd4, rd_v, err_v); chk("lvl_after_rst", rd_v, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
